// File: rtl/noc_ni_pkg.sv
// Shared definitions for the core-to-NoC network interface.
//   - Data/address widths and FIFO geometry
//   - AXI4-Lite-side register offsets (decoded on address bits [3:2])
//   - STAT word bit positions plus a helper that packs the STAT word
//   - FIFO entry layout: {tag, data}
package noc_ni_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 16;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Register offsets seen from the AXI4 side; only bits [3:2] are decoded.
  localparam logic [ADDR_W-1:0] REG_DATA = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] REG_TAG  = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] REG_STAT = 32'h0000_0008;

  // STAT word layout.
  localparam int STAT_OCUP_LSB  = 0;
  localparam int STAT_EMPTY_BIT = 5;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_ERROR_BIT = 7;

  typedef struct packed {
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [DATA_W-1:0] pack_stat(
    input logic [CNT_W-1:0] ocup,
    input logic             empty,
    input logic             full,
    input logic             error
  );
    logic [DATA_W-1:0] word;
    word = '0;
    word[STAT_OCUP_LSB +: CNT_W] = ocup;
    word[STAT_EMPTY_BIT]         = empty;
    word[STAT_FULL_BIT]          = full;
    word[STAT_ERROR_BIT]         = error;
    return word;
  endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO holding {tag, data} entries for the network interface.
//
// Handshake: push is a request that is taken only when full=0 at the edge;
// pop is a request that is taken only when empty=0 at the edge. A refused
// request has no side effect here (the caller decides whether it is an error).
// Both may be taken on the same edge; count is then unchanged.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset
//   push         enqueue request, push_entry stored at wr_ptr when taken
//   pop          dequeue request, rd_ptr advances when taken
//   head_entry   entry at rd_ptr (combinational; meaningful when !empty)
//   count        number of stored entries, 0..DEPTH
//   empty, full  decoded from count
module ni_sync_fifo
  import noc_ni_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head_entry,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == CNT_W'(0));
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_entry = mem[rd_ptr];

  // Storage is deliberately not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers are PTR_W bits wide and wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_ni.sv
// Network interface between a processing core and the AXI4-Lite side of the NoC.
// The core enqueues {addr tag, data} words; the AXI4 side pops them in order
// through a small register window decoded on axi4_read_addr[3:2]:
//   0x0 DATA  pop head, return its data
//   0x4 TAG   peek head, return its address tag
//   0x8 STAT  {error, full, empty, ocup}
//   0xC       reserved, returns 0
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   core_write_data   word to enqueue
//   core_write_addr   destination tag stored with the word
//   core_write_en     enqueue request; refused when full (sets core_error)
//   core_empty        FIFO holds no entries
//   core_error        sticky overflow flag, cleared only by reset
//   axi4_read_data    registered read result, valid one edge after the request
//   axi4_read_addr    register select
//   axi4_read_en      read request
//   axi4_full         FIFO holds DEPTH entries
//   axi4_ocup         current entry count
module noc_ni
  import noc_ni_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] core_write_data,
  input  logic [ADDR_W-1:0] core_write_addr,
  input  logic              core_write_en,
  output logic              core_empty,
  output logic              core_error,
  output logic [DATA_W-1:0] axi4_read_data,
  input  logic [ADDR_W-1:0] axi4_read_addr,
  input  logic              axi4_read_en,
  output logic              axi4_full,
  output logic [CNT_W-1:0]  axi4_ocup
);

  entry_t           push_entry;
  entry_t           head_entry;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic [1:0]       sel;
  logic             pop_req;
  logic             unused_addr_bits;

  assign sel        = axi4_read_addr[3:2];
  assign pop_req    = axi4_read_en && (sel == REG_DATA[3:2]);
  assign push_entry = '{tag: core_write_addr, data: core_write_data};

  // Only bits [3:2] of the read address select a register.
  assign unused_addr_bits = ^{axi4_read_addr[ADDR_W-1:4], axi4_read_addr[1:0]};

  ni_sync_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (core_write_en),
    .push_entry (push_entry),
    .pop        (pop_req),
    .head_entry (head_entry),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  assign core_empty = empty;
  assign axi4_full  = full;
  assign axi4_ocup  = count;

  // Overflow is judged on the pre-edge full flag, so a write coinciding with
  // a pop from a full FIFO is still refused and still flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_error <= 1'b0;
    end else if (core_write_en && full) begin
      core_error <= 1'b1;
    end
  end

  // Read result register: holds its value unless a read updates it. DATA/TAG
  // reads of an empty FIFO leave it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      axi4_read_data <= '0;
    end else if (axi4_read_en) begin
      case (sel)
        REG_DATA[3:2]: begin
          if (!empty) axi4_read_data <= head_entry.data;
        end
        REG_TAG[3:2]: begin
          if (!empty) axi4_read_data <= head_entry.tag;
        end
        REG_STAT[3:2]: axi4_read_data <= pack_stat(count, empty, full, core_error);
        default:       axi4_read_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ni.sv
module tb_noc_ni;

  logic        clk;
  logic        reset;
  logic [31:0] core_write_data;
  logic [31:0] core_write_addr;
  logic        core_write_en;
  logic        core_empty;
  logic        core_error;
  logic [31:0] axi4_read_data;
  logic [31:0] axi4_read_addr;
  logic        axi4_read_en;
  logic        axi4_full;
  logic [4:0]  axi4_ocup;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  noc_ni dut (
    .clk             (clk),
    .reset           (reset),
    .core_write_data (core_write_data),
    .core_write_addr (core_write_addr),
    .core_write_en   (core_write_en),
    .core_empty      (core_empty),
    .core_error      (core_error),
    .axi4_read_data  (axi4_read_data),
    .axi4_read_addr  (axi4_read_addr),
    .axi4_read_en    (axi4_read_en),
    .axi4_full       (axi4_full),
    .axi4_ocup       (axi4_ocup)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [31:0] wdata;
    logic [31:0] waddr;
    logic        re;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_ocup;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [31:0] wdata, input logic [31:0] waddr,
                       input logic re, input logic [31:0] raddr);
    core_write_en   = we;
    core_write_data = wdata;
    core_write_addr = waddr;
    axi4_read_en    = re;
    axi4_read_addr  = raddr;
  endtask

  // One active edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [4:0] ocup, input logic empty,
                             input logic full, input logic err);
    check({tag, " ocup"},  32'(axi4_ocup),  32'(ocup));
    check({tag, " empty"}, 32'(core_empty), 32'(empty));
    check({tag, " full"},  32'(axi4_full),  32'(full));
    check({tag, " error"}, 32'(core_error), 32'(err));
  endtask

  function automatic logic [31:0] stat_word(input logic [4:0] ocup, input logic empty,
                                            input logic full, input logic err);
    return {24'b0, err, full, empty, ocup};
  endfunction

  // ---------------- test ----------------
  initial begin
    // idx: we wdata waddr re raddr | rdata ocup empty full err
    vecs[0]  = '{1'b1, 32'hA5A5A5A5, 32'h0,        1'b0, 32'h0, 32'h00000000, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'hA5A5A1A5, 32'h0,        1'b0, 32'h0, 32'h00000000, 5'd2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h0, 32'hA5A5A5A5, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h0, 32'hA5A5A1A5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h0, 32'hA5A5A1A5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hDEADBEEF, 32'h12340000, 1'b0, 32'h0, 32'hA5A5A1A5, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h4, 32'h12340000, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h8, 32'h00000001, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'hC, 32'h00000000, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h7, 32'h12340000, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h11111111, 32'h0,        1'b1, 32'h0, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h0, 32'h11111111, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h22222222, 32'hCAFE0000, 1'b1, 32'h0, 32'h11111111, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h4, 32'hCAFE0000, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h1, 32'h22222222, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h8, 32'h00000020, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h4, 32'h00000020, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'hC, 32'h00000000, 5'd0, 1'b1, 1'b0, 1'b0};

    // Reset for two cycles.
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 5'd0, 1'b1, 1'b0, 1'b0);
    check("reset rdata", axi4_read_data, 32'h0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, vecs[i].wdata, vecs[i].waddr, vecs[i].re, vecs[i].raddr);
      step();
      check($sformatf("vec%0d rdata", i), axi4_read_data, vecs[i].exp_rdata);
      check_flags($sformatf("vec%0d", i), vecs[i].exp_ocup, vecs[i].exp_empty,
                  vecs[i].exp_full, vecs[i].exp_err);
    end

    // Overflow: 17 writes, 17th dropped and flagged.
    begin
      int cnt;
      logic err;
      cnt = 0;
      err = 1'b0;
      for (int i = 0; i < 17; i++) begin
        drive(1'b1, 32'h1000 + 32'(i), 32'(i) << 16, 1'b0, 32'h0);
        step();
        if (cnt < 16) begin
          exp_q.push_back(32'h1000 + 32'(i));
          cnt++;
        end else begin
          err = 1'b1;
        end
        check_flags($sformatf("fill%0d", i), 5'(cnt), 1'b0, cnt == 16, err);
      end
    end

    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h8);
    step();
    check("stat full", axi4_read_data, stat_word(5'd16, 1'b0, 1'b1, 1'b1));
    check("stat full const", axi4_read_data, 32'h000000D0);

    // Write + pop while full: pop happens, write refused.
    drive(1'b1, 32'hBAD0BAD0, 32'h0, 1'b1, 32'h0);
    step();
    check("full wr+pop rdata", axi4_read_data, exp_q.pop_front());
    check_flags("full wr+pop", 5'd15, 1'b0, 1'b0, 1'b1);

    // Drain the rest in order.
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      step();
      check($sformatf("drain%0d rdata", i), axi4_read_data, exp_q.pop_front());
      check_flags($sformatf("drain%0d", i), 5'(14 - i), i == 14, 1'b0, 1'b1);
    end

    // Three entries, then four cycles of simultaneous write + pop.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h3000 + 32'(k), 32'h0, 1'b0, 32'h0);
      step();
      exp_q.push_back(32'h3000 + 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h3100 + 32'(k), 32'h0, 1'b1, 32'h0);
      step();
      exp_q.push_back(32'h3100 + 32'(k));
      check($sformatf("stream%0d rdata", k), axi4_read_data, exp_q.pop_front());
      check_flags($sformatf("stream%0d", k), 5'd3, 1'b0, 1'b0, 1'b1);
    end

    // Grow to five entries, then reset with requests active.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h4000 + 32'(k), 32'h0, 1'b0, 32'h0);
      step();
    end
    check("pre-reset ocup", 32'(axi4_ocup), 32'd5);
    reset = 1'b1;
    drive(1'b1, 32'h5A5A5A5A, 32'h0, 1'b1, 32'h0);
    step();
    check_flags("midreset", 5'd0, 1'b1, 1'b0, 1'b0);
    check("midreset rdata", axi4_read_data, 32'h0);
    reset = 1'b0;
    exp_q.delete();

    // Normal operation resumes after reset.
    drive(1'b1, 32'h00005555, 32'h00AA0000, 1'b0, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h4);
    step();
    check("post-reset tag", axi4_read_data, 32'h00AA0000);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    step();
    check("post-reset data", axi4_read_data, 32'h00005555);
    check_flags("post-reset", 5'd0, 1'b1, 1'b0, 1'b0);

    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
